// File: rtl/mux_stream_rr_nx1_if.sv
// Stream bundle for the N-to-1 mux: N producer channels in, one consumer stream out.
// The mux attaches through the slave modport; producers/consumer drive the master side.
interface mux_stream_rr_nx1_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/mux_stream_rr_nx1.sv
// N-to-1 streaming mux with round-robin or fixed-priority arbitration, optional
// packet locking on in_last, and a single registered output stage.
module mux_stream_rr_nx1 #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 8,
  parameter int ROUND_ROBIN = 1,
  parameter int PACKET_LOCK = 1,
  localparam int SELW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  mux_stream_rr_nx1_if.slave  bus,
  output logic [SELW-1:0]     grant,
  output logic                busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_reg;
  logic [SELW-1:0]     grant_reg;
  logic [SELW-1:0]     rr_ptr_reg;
  logic [WIDTH-1:0]    out_data_reg;
  logic                out_valid_reg;
  logic                out_last_reg;
  logic                busy_reg;

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [SELW-1:0]     winner;
  logic                found;
  logic [SELW-1:0]     take_idx;
  logic [CHANNELS-1:0] in_ready_c;
  logic                load_ok;
  logic                take;
  logic                take_last;
  int                  idx;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search order starts just after the pointer (round-robin) or at channel 0
  // (fixed priority); the modulo keeps unused codes out of the rotation.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ROUND_ROBIN != 0) idx = (int'(rr_ptr_reg) + 1 + k) % CHANNELS;
      else                  idx = k;
      if (!found && bus.in_valid[idx]) begin
        found  = 1'b1;
        winner = SELW'(idx);
      end
    end
  end

  assign load_ok = !out_valid_reg || bus.out_ready;

  always_comb begin
    in_ready_c = '0;
    take_idx   = winner;
    if (state_reg == LOCKED) begin
      // Mid-packet the locked channel keeps going regardless of en.
      take_idx             = grant_reg;
      in_ready_c[grant_reg] = load_ok;
    end else if (en && load_ok && found) begin
      in_ready_c[winner] = 1'b1;
    end
  end

  assign take      = |(bus.in_valid & in_ready_c);
  assign take_last = bus.in_last[take_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= SELW'(CHANNELS - 1);
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      if (take) begin
        out_data_reg  <= ch_data[take_idx];
        out_valid_reg <= 1'b1;
        out_last_reg  <= take_last;
        grant_reg     <= take_idx;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (take) begin
            rr_ptr_reg <= winner;
            if ((PACKET_LOCK != 0) && !take_last) begin
              state_reg <= LOCKED;
              busy_reg  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (take && take_last) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign grant         = grant_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_mux_stream_rr_nx1.sv
// Directed bench for mux_stream_rr_nx1: 8-ch round-robin with packet lock,
// 8-ch fixed priority, and 5-ch round-robin without packet lock.
module tb_mux_stream_rr_nx1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en8, en_fp, en5;
  logic [2:0] g8, gfp, g5;
  logic b8, bfp, b5;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mux_stream_rr_nx1_if #(.WIDTH(8), .CHANNELS(8)) m8 ();
  mux_stream_rr_nx1_if #(.WIDTH(8), .CHANNELS(8)) mfp ();
  mux_stream_rr_nx1_if #(.WIDTH(8), .CHANNELS(5)) m5 ();

  mux_stream_rr_nx1 #(.WIDTH(8), .CHANNELS(8), .ROUND_ROBIN(1), .PACKET_LOCK(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en8), .bus(m8.slave), .grant(g8), .busy(b8));
  mux_stream_rr_nx1 #(.WIDTH(8), .CHANNELS(8), .ROUND_ROBIN(0), .PACKET_LOCK(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .en(en_fp), .bus(mfp.slave), .grant(gfp), .busy(bfp));
  mux_stream_rr_nx1 #(.WIDTH(8), .CHANNELS(5), .ROUND_ROBIN(1), .PACKET_LOCK(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .bus(m5.slave), .grant(g5), .busy(b5));

  always @(negedge clk)
    if (rst_n && m8.out_valid && m8.out_ready)
      $display("[TB] beat grant=%0d data=%h last=%b", g8, m8.out_data, m8.out_last);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    m8.in_valid = '0;  m8.in_last = '0;  m8.in_data = '0;  m8.out_ready = 1'b1;
    mfp.in_valid = '0; mfp.in_last = '0; mfp.in_data = '0; mfp.out_ready = 1'b1;
    m5.in_valid = '0;  m5.in_last = '0;  m5.in_data = '0;  m5.out_ready = 1'b1;
    en8 = 1'b1; en_fp = 1'b1; en5 = 1'b1;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input int i, input logic v, input logic l, input logic [7:0] d);
    m8.in_valid[i] = v;
    m8.in_last[i]  = l;
    m8.in_data[i*8 +: 8] = d;
  endtask

  task automatic test_reset;
    #2;
    tests_run++; if (m8.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", m8.out_valid); end
    tests_run++; if (m8.out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data: got %h want 00", m8.out_data); end
    tests_run++; if (g8 !== 3'd0 || b8 !== 1'b0) begin tests_failed++; $display("FAIL reset_grant_busy: got %0d/%b want 0/0", g8, b8); end
    @(negedge clk);
    rst_n = 1'b1;
    set_ch(2, 1'b1, 1'b0, 8'h2A);
    tick();
    tests_run++; if (g8 !== 3'd2 || b8 !== 1'b1) begin tests_failed++; $display("FAIL reset_prepkt: got grant %0d busy %b want 2/1", g8, b8); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (m8.out_valid !== 1'b0 || b8 !== 1'b0 || g8 !== 3'd0) begin
      tests_failed++; $display("FAIL reset_midpkt: got valid %b busy %b grant %0d want 0/0/0", m8.out_valid, b8, g8); end
    clear_inputs();
    tick();
    rst_n = 1'b1;
    set_ch(0, 1'b1, 1'b1, 8'h01);
    set_ch(3, 1'b1, 1'b1, 8'h31);
    tick();
    tests_run++; if (g8 !== 3'd0 || m8.out_data !== 8'h01) begin tests_failed++; $display("FAIL reset_first_grant: got %0d/%h want 0/01", g8, m8.out_data); end
    tick();
    tests_run++; if (g8 !== 3'd3 || m8.out_data !== 8'h31) begin tests_failed++; $display("FAIL reset_second_grant: got %0d/%h want 3/31", g8, m8.out_data); end
  endtask

  task automatic test_round_robin;
    apply_reset();
    for (int i = 0; i < 8; i++) set_ch(i, 1'b1, 1'b1, 8'(i*16 + 5));
    for (int k = 0; k < 9; k++) begin
      #1;
      tests_run++; if (m8.in_ready !== 8'(1 << (k % 8))) begin tests_failed++; $display("FAIL rr_ready[%0d]: got %b want %b", k, m8.in_ready, 8'(1 << (k % 8))); end
      tick();
      tests_run++; if (g8 !== 3'(k % 8) || m8.out_data !== 8'((k % 8)*16 + 5) || m8.out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL rr_grant[%0d]: got %0d/%h/%b want %0d/%h/1", k, g8, m8.out_data, m8.out_valid, k % 8, 8'((k % 8)*16 + 5)); end
    end
  endtask

  task automatic test_packet_lock;
    apply_reset();
    set_ch(5, 1'b1, 1'b1, 8'h55);
    set_ch(2, 1'b1, 1'b0, 8'h21);
    for (int b = 1; b <= 4; b++) begin
      #1;
      tests_run++; if (m8.in_ready !== 8'h04) begin tests_failed++; $display("FAIL lock_ready[%0d]: got %b want 00000100", b, m8.in_ready); end
      tick();
      tests_run++; if (m8.out_data !== 8'(8'h20 + b) || g8 !== 3'd2 || b8 !== (b < 4)) begin
        tests_failed++; $display("FAIL lock_beat[%0d]: got %h/%0d/%b want %h/2/%b", b, m8.out_data, g8, b8, 8'(8'h20 + b), (b < 4)); end
      if (b < 4) set_ch(2, 1'b1, (b + 1 == 4), 8'(8'h20 + b + 1));
      else       set_ch(2, 1'b0, 1'b0, 8'h00);
    end
    tests_run++; if (m8.out_last !== 1'b1) begin tests_failed++; $display("FAIL lock_out_last: got %b want 1", m8.out_last); end
    #1;
    tests_run++; if (m8.in_ready !== 8'h20) begin tests_failed++; $display("FAIL lock_release_ready: got %b want 00100000", m8.in_ready); end
    tick();
    tests_run++; if (m8.out_data !== 8'h55 || g8 !== 3'd5) begin tests_failed++; $display("FAIL lock_next_ch: got %h/%0d want 55/5", m8.out_data, g8); end
  endtask

  task automatic test_backpressure;
    apply_reset();
    set_ch(3, 1'b1, 1'b1, 8'h31);
    tick();
    m8.out_ready = 1'b0;
    set_ch(3, 1'b1, 1'b1, 8'h32);
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (m8.in_ready !== 8'h00) begin tests_failed++; $display("FAIL bp_ready[%0d]: got %b want 0", c, m8.in_ready); end
      tick();
      tests_run++; if (m8.out_data !== 8'h31 || m8.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold[%0d]: got %h/%b want 31/1", c, m8.out_data, m8.out_valid); end
    end
    m8.out_ready = 1'b1;
    #1;
    tests_run++; if (m8.in_ready !== 8'h08) begin tests_failed++; $display("FAIL bp_resume_ready: got %b want 00001000", m8.in_ready); end
    tick();
    tests_run++; if (m8.out_data !== 8'h32) begin tests_failed++; $display("FAIL bp_next: got %h want 32", m8.out_data); end
    set_ch(3, 1'b1, 1'b1, 8'h33);
    tick();
    tests_run++; if (m8.out_data !== 8'h33) begin tests_failed++; $display("FAIL bp_after: got %h want 33", m8.out_data); end
    set_ch(3, 1'b0, 1'b0, 8'h00);
    tick();
    tests_run++; if (m8.out_valid !== 1'b0 || m8.out_data !== 8'h33) begin tests_failed++; $display("FAIL bp_drain: got %b/%h want 0/33", m8.out_valid, m8.out_data); end
  endtask

  task automatic test_enable;
    apply_reset();
    set_ch(1, 1'b1, 1'b0, 8'h11);
    tick();
    tests_run++; if (b8 !== 1'b1 || g8 !== 3'd1) begin tests_failed++; $display("FAIL en_lock: got busy %b grant %0d want 1/1", b8, g8); end
    en8 = 1'b0;
    set_ch(4, 1'b1, 1'b1, 8'h41);
    set_ch(1, 1'b1, 1'b0, 8'h12);
    #1;
    tests_run++; if (m8.in_ready !== 8'h02) begin tests_failed++; $display("FAIL en_locked_ready: got %b want 00000010", m8.in_ready); end
    tick();
    tests_run++; if (m8.out_data !== 8'h12) begin tests_failed++; $display("FAIL en_beat2: got %h want 12", m8.out_data); end
    set_ch(1, 1'b1, 1'b1, 8'h13);
    tick();
    tests_run++; if (m8.out_data !== 8'h13 || b8 !== 1'b0) begin tests_failed++; $display("FAIL en_beat3: got %h/%b want 13/0", m8.out_data, b8); end
    set_ch(1, 1'b0, 1'b0, 8'h00);
    #1;
    tests_run++; if (m8.in_ready !== 8'h00) begin tests_failed++; $display("FAIL en_blocked: got %b want 0", m8.in_ready); end
    tick();
    tests_run++; if (m8.out_valid !== 1'b0) begin tests_failed++; $display("FAIL en_drained: got %b want 0", m8.out_valid); end
    en8 = 1'b1;
    #1;
    tests_run++; if (m8.in_ready !== 8'h10) begin tests_failed++; $display("FAIL en_reenable_ready: got %b want 00010000", m8.in_ready); end
    tick();
    tests_run++; if (m8.out_data !== 8'h41 || g8 !== 3'd4) begin tests_failed++; $display("FAIL en_ch4: got %h/%0d want 41/4", m8.out_data, g8); end
  endtask

  task automatic test_fixed_priority;
    apply_reset();
    mfp.in_valid = 8'b0100_0010;
    mfp.in_last  = 8'hFF;
    mfp.in_data[1*8 +: 8] = 8'h1F;
    mfp.in_data[6*8 +: 8] = 8'h6F;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++; if (mfp.in_ready !== 8'h02) begin tests_failed++; $display("FAIL fp_ready[%0d]: got %b want 00000010", k, mfp.in_ready); end
      tick();
      tests_run++; if (gfp !== 3'd1 || mfp.out_data !== 8'h1F) begin tests_failed++; $display("FAIL fp_grant[%0d]: got %0d/%h want 1/1F", k, gfp, mfp.out_data); end
    end
  endtask

  task automatic test_five_channels;
    apply_reset();
    m5.in_valid = 5'b11111;
    m5.in_last  = 5'b00000;
    for (int i = 0; i < 5; i++) m5.in_data[i*8 +: 8] = 8'(i*16 + 7);
    for (int k = 0; k < 6; k++) begin
      tick();
      tests_run++; if (g5 !== 3'(k % 5) || m5.out_data !== 8'((k % 5)*16 + 7) || b5 !== 1'b0) begin
        tests_failed++; $display("FAIL ch5_rot[%0d]: got %0d/%h/busy %b want %0d/%h/0", k, g5, m5.out_data, b5, k % 5, 8'((k % 5)*16 + 7)); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_enable();
    test_fixed_priority();
    test_five_channels();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
